pipe_hazard_ctrl: RTL and testbench

//  Central hazard/flush/halt controller for the 5-stage pipeline; replaces hard-wired EX_flush/MEM_flush chaining.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/hazard_fwd_sel.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t          : hazard controller FSM state encoding
//   FWD_REG/MEM/WB   : EX operand forwarding select codes
//   NOP_INST         : instruction word that IF/ID loads on flush
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [1:0]  FWD_REG  = 2'b00;
    localparam logic [1:0]  FWD_MEM  = 2'b01;
    localparam logic [1:0]  FWD_WB   = 2'b10;

    localparam logic [15:0] NOP_INST = 16'h1000;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX source operand.
//   i_src / i_src_used            : EX operand index and whether it is read
//   i_mem_write_en/_reg           : MEM stage destination
//   i_wb_write_en/_reg            : WB stage destination
//   o_fwd_sel                     : 00 regfile, 01 MEM, 10 WB (MEM is newer, so it wins)
import pipe_pkg::*;

module hazard_fwd_sel #(
    parameter int REG_AW      = 3,
    parameter int ZERO_REG_HW = 0
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_src_used,
    input  logic              i_mem_write_en,
    input  logic [REG_AW-1:0] i_mem_write_reg,
    input  logic              i_wb_write_en,
    input  logic [REG_AW-1:0] i_wb_write_reg,
    output logic [1:0]        o_fwd_sel
);

    logic w_zero;
    logic w_mem_hit;
    logic w_wb_hit;

    // A hardwired-zero register holds no produced value worth forwarding.
    assign w_zero    = (ZERO_REG_HW != 0) && (i_src == '0);
    assign w_mem_hit = i_src_used && !w_zero && i_mem_write_en && (i_src == i_mem_write_reg);
    assign w_wb_hit  = i_src_used && !w_zero && i_wb_write_en  && (i_src == i_wb_write_reg);

    assign o_fwd_sel = w_mem_hit ? FWD_MEM : (w_wb_hit ? FWD_WB : FWD_REG);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard / flush / halt controller for the 5-stage pipeline.
//   i_clk, i_rst                  : clock, synchronous active-high reset
//   i_id_*                        : DEC instruction sources (load-use detect)
//   i_ex_*                        : EX sources, load flag, destination, redirect
//   i_mem_*, i_wb_*               : later-stage destinations (forwarding)
//   i_wb_halt                     : halt reached WB, freezes the pipe
//   o_pc_en, o_fd_en, o_fd_flush  : PC / IF-ID control (flush beats hold)
//   o_dx_flush                    : ID/EX loads a bubble
//   o_fwd_sel                     : 2 bits per EX operand
//   o_halted                      : pipe frozen
//   o_stall_cnt, o_flush_cnt      : saturating perf counters
import pipe_pkg::*;

module pipe_hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int NUM_SRC      = 2,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int ZERO_REG_HW  = 0,
    parameter int CNT_W        = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] i_id_src,
    input  logic [NUM_SRC-1:0]        i_id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0] i_ex_src,
    input  logic [NUM_SRC-1:0]        i_ex_src_used,
    input  logic                      i_ex_mem_read,
    input  logic                      i_ex_write_en,
    input  logic [REG_AW-1:0]         i_ex_write_reg,
    input  logic                      i_ex_redirect,
    input  logic                      i_mem_write_en,
    input  logic [REG_AW-1:0]         i_mem_write_reg,
    input  logic                      i_wb_write_en,
    input  logic [REG_AW-1:0]         i_wb_write_reg,
    input  logic                      i_wb_halt,
    output logic                      o_pc_en,
    output logic                      o_fd_en,
    output logic                      o_fd_flush,
    output logic                      o_dx_flush,
    output logic [NUM_SRC*2-1:0]      o_fwd_sel,
    output logic                      o_halted,
    output logic [CNT_W-1:0]          o_stall_cnt,
    output logic [CNT_W-1:0]          o_flush_cnt
);

    localparam int MAXC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic w_src_hit, w_hazard;
    logic w_do_halt, w_do_redir, w_do_stall;

    // Load-use: DEC reads the register a load in EX has not produced yet.
    always_comb begin
        w_src_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (i_id_src_used[k] && (i_id_src[k*REG_AW +: REG_AW] == i_ex_write_reg))
                w_src_hit = 1'b1;
        end
    end

    assign w_hazard = i_id_valid && i_ex_mem_read && i_ex_write_en && w_src_hit
                      && !((ZERO_REG_HW != 0) && (i_ex_write_reg == '0));

    // Per-cycle action, priority halt > redirect > stall.
    assign w_do_halt  = (r_state != ST_HALTED) && i_wb_halt;
    assign w_do_redir = (r_state != ST_HALTED) && !i_wb_halt && i_ex_redirect;
    assign w_do_stall = !w_do_halt && !w_do_redir && (r_state != ST_HALTED)
                        && (((r_state == ST_RUN) && w_hazard) || (r_state == ST_STALL));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state; r_cnt holds the remaining hold cycles in STALL/FLUSH.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_do_halt) begin
            w_state_nxt = ST_HALTED;
        end else if (w_do_redir) begin
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = ST_FLUSH;
                w_cnt_nxt   = CW'(FLUSH_CYCLES - 1);
            end else begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        end else if ((r_state == ST_RUN) && w_hazard) begin
            if (STALL_CYCLES > 1) begin
                w_state_nxt = ST_STALL;
                w_cnt_nxt   = CW'(STALL_CYCLES - 1);
            end
        end else if ((r_state == ST_STALL) || (r_state == ST_FLUSH)) begin
            if (r_cnt <= CW'(1)) begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt - CW'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        o_pc_en    = 1'b1;
        o_fd_en    = 1'b1;
        o_fd_flush = 1'b0;
        o_dx_flush = 1'b0;
        o_halted   = (r_state == ST_HALTED);
        if ((r_state == ST_HALTED) || w_do_halt || w_do_stall) begin
            o_pc_en    = 1'b0;
            o_fd_en    = 1'b0;
            o_dx_flush = 1'b1;
        end else if (w_do_redir) begin
            o_fd_flush = 1'b1;
            o_dx_flush = 1'b1;
        end else if (r_state == ST_FLUSH) begin
            o_fd_flush = 1'b1;
        end
    end

    // Saturating perf counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_do_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_do_redir && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_fwd
            hazard_fwd_sel #(
                .REG_AW      (REG_AW),
                .ZERO_REG_HW (ZERO_REG_HW)
            ) u_fwd (
                .i_src           (i_ex_src[g*REG_AW +: REG_AW]),
                .i_src_used      (i_ex_src_used[g]),
                .i_mem_write_en  (i_mem_write_en),
                .i_mem_write_reg (i_mem_write_reg),
                .i_wb_write_en   (i_wb_write_en),
                .i_wb_write_reg  (i_wb_write_reg),
                .o_fwd_sel       (o_fwd_sel[g*2 +: 2])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Two controller instances share stimulus:
//   dut_a: defaults (STALL_CYCLES=1, FLUSH_CYCLES=2, ZERO_REG_HW=0, CNT_W=16)
//   dut_b: STALL_CYCLES=3, FLUSH_CYCLES=1, ZERO_REG_HW=1, CNT_W=4
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_src;
    logic [1:0] id_src_used;
    logic [5:0] ex_src;
    logic [1:0] ex_src_used;
    logic       ex_mem_read, ex_write_en, ex_redirect;
    logic [2:0] ex_write_reg;
    logic       mem_write_en, wb_write_en, wb_halt;
    logic [2:0] mem_write_reg, wb_write_reg;

    logic        a_pc_en, a_fd_en, a_fd_flush, a_dx_flush, a_halted;
    logic [3:0]  a_fwd;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_en, b_fd_en, b_fd_flush, b_dx_flush, b_halted;
    logic [3:0]  b_fwd;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut_a (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_src(id_src),
        .i_id_src_used(id_src_used), .i_ex_src(ex_src), .i_ex_src_used(ex_src_used),
        .i_ex_mem_read(ex_mem_read), .i_ex_write_en(ex_write_en), .i_ex_write_reg(ex_write_reg),
        .i_ex_redirect(ex_redirect), .i_mem_write_en(mem_write_en), .i_mem_write_reg(mem_write_reg),
        .i_wb_write_en(wb_write_en), .i_wb_write_reg(wb_write_reg), .i_wb_halt(wb_halt),
        .o_pc_en(a_pc_en), .o_fd_en(a_fd_en), .o_fd_flush(a_fd_flush), .o_dx_flush(a_dx_flush),
        .o_fwd_sel(a_fwd), .o_halted(a_halted), .o_stall_cnt(a_stall_cnt), .o_flush_cnt(a_flush_cnt)
    );

    pipe_hazard_ctrl #(
        .STALL_CYCLES(3), .FLUSH_CYCLES(1), .ZERO_REG_HW(1), .CNT_W(4)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_src(id_src),
        .i_id_src_used(id_src_used), .i_ex_src(ex_src), .i_ex_src_used(ex_src_used),
        .i_ex_mem_read(ex_mem_read), .i_ex_write_en(ex_write_en), .i_ex_write_reg(ex_write_reg),
        .i_ex_redirect(ex_redirect), .i_mem_write_en(mem_write_en), .i_mem_write_reg(mem_write_reg),
        .i_wb_write_en(wb_write_en), .i_wb_write_reg(wb_write_reg), .i_wb_halt(wb_halt),
        .o_pc_en(b_pc_en), .o_fd_en(b_fd_en), .o_fd_flush(b_fd_flush), .o_dx_flush(b_dx_flush),
        .o_fwd_sel(b_fwd), .o_halted(b_halted), .o_stall_cnt(b_stall_cnt), .o_flush_cnt(b_flush_cnt)
    );

    task automatic idle();
        id_valid = 0; id_src = '0; id_src_used = '0; ex_src = '0; ex_src_used = '0;
        ex_mem_read = 0; ex_write_en = 0; ex_write_reg = '0; ex_redirect = 0;
        mem_write_en = 0; mem_write_reg = '0; wb_write_en = 0; wb_write_reg = '0; wb_halt = 0;
    endtask

    // lw r1 in EX, add r2,r1,r3 in DEC
    task automatic set_hazard();
        id_valid = 1; id_src = {3'd3, 3'd1}; id_src_used = 2'b01;
        ex_mem_read = 1; ex_write_en = 1; ex_write_reg = 3'd1;
    endtask

    // clock edge, then settle away from it
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0; #1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if ({a_pc_en, a_fd_en, a_fd_flush, a_dx_flush, a_halted} !== 5'b11000)
            $display("FAIL rst_a_ctrl got %b exp 11000", {a_pc_en, a_fd_en, a_fd_flush, a_dx_flush, a_halted}); else pass_cnt++;
        total_cnt++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0)
            $display("FAIL rst_a_cnt got %0d/%0d exp 0/0", a_stall_cnt, a_flush_cnt); else pass_cnt++;
        total_cnt++; if ({b_pc_en, b_fd_en, b_fd_flush, b_dx_flush, b_halted} !== 5'b11000)
            $display("FAIL rst_b_ctrl got %b exp 11000", {b_pc_en, b_fd_en, b_fd_flush, b_dx_flush, b_halted}); else pass_cnt++;
        // reset while dut_b is mid-STALL
        set_hazard(); step(); idle(); #1;
        total_cnt++; if (b_pc_en !== 1'b0)
            $display("FAIL midstall_pre got %b exp 0", b_pc_en); else pass_cnt++;
        rst = 1; step(); rst = 0; #1;
        total_cnt++; if (b_pc_en !== 1'b1 || b_dx_flush !== 1'b0 || b_stall_cnt !== 4'd0)
            $display("FAIL midstall_rst got pc=%b dx=%b cnt=%0d exp 1 0 0", b_pc_en, b_dx_flush, b_stall_cnt); else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_hazard(); #1;
        total_cnt++; if ({a_pc_en, a_fd_en, a_dx_flush, a_fd_flush} !== 4'b0010)
            $display("FAIL lu_a_bubble got %b exp 0010", {a_pc_en, a_fd_en, a_dx_flush, a_fd_flush}); else pass_cnt++;
        step(); idle(); #1;
        total_cnt++; if (a_pc_en !== 1'b1 || a_dx_flush !== 1'b0 || a_stall_cnt !== 16'd1)
            $display("FAIL lu_a_after got pc=%b dx=%b cnt=%0d exp 1 0 1", a_pc_en, a_dx_flush, a_stall_cnt); else pass_cnt++;
        total_cnt++; if (b_pc_en !== 1'b0 || b_dx_flush !== 1'b1 || b_stall_cnt !== 4'd1)
            $display("FAIL lu_b_cyc1 got pc=%b dx=%b cnt=%0d exp 0 1 1", b_pc_en, b_dx_flush, b_stall_cnt); else pass_cnt++;
        step();
        total_cnt++; if (b_pc_en !== 1'b0 || b_stall_cnt !== 4'd2)
            $display("FAIL lu_b_cyc2 got pc=%b cnt=%0d exp 0 2", b_pc_en, b_stall_cnt); else pass_cnt++;
        step();
        total_cnt++; if (b_pc_en !== 1'b1 || b_dx_flush !== 1'b0 || b_stall_cnt !== 4'd3)
            $display("FAIL lu_b_done got pc=%b dx=%b cnt=%0d exp 1 0 3", b_pc_en, b_dx_flush, b_stall_cnt); else pass_cnt++;
        // same registers, operand not read
        set_hazard(); id_src_used = 2'b00; #1;
        total_cnt++; if (a_pc_en !== 1'b1 || b_pc_en !== 1'b1 || a_dx_flush !== 1'b0)
            $display("FAIL lu_unused got a=%b b=%b dx=%b exp 1 1 0", a_pc_en, b_pc_en, a_dx_flush); else pass_cnt++;
        // load into r0: hazard only where r0 is not hardwired
        id_src = 6'b000_000; id_src_used = 2'b01; ex_write_reg = 3'd0; #1;
        total_cnt++; if (a_pc_en !== 1'b0 || b_pc_en !== 1'b1)
            $display("FAIL lu_zero got a=%b b=%b exp 0 1", a_pc_en, b_pc_en); else pass_cnt++;
        step(); idle(); #1;
        total_cnt++; if (a_stall_cnt !== 16'd2 || b_stall_cnt !== 4'd3)
            $display("FAIL lu_cnts got a=%0d b=%0d exp 2 3", a_stall_cnt, b_stall_cnt); else pass_cnt++;
    endtask

    task automatic test_redirect();
        do_reset();
        ex_redirect = 1; #1;
        total_cnt++; if ({a_pc_en, a_fd_flush, a_dx_flush} !== 3'b111)
            $display("FAIL rd_cyc0 got %b exp 111", {a_pc_en, a_fd_flush, a_dx_flush}); else pass_cnt++;
        step(); ex_redirect = 0; #1;
        total_cnt++; if ({a_pc_en, a_fd_flush, a_dx_flush} !== 3'b110 || a_flush_cnt !== 16'd1)
            $display("FAIL rd_cyc1 got %b cnt=%0d exp 110 1", {a_pc_en, a_fd_flush, a_dx_flush}, a_flush_cnt); else pass_cnt++;
        total_cnt++; if (b_fd_flush !== 1'b0 || b_flush_cnt !== 4'd1)
            $display("FAIL rd_b_single got fd=%b cnt=%0d exp 0 1", b_fd_flush, b_flush_cnt); else pass_cnt++;
        step();
        total_cnt++; if (a_fd_flush !== 1'b0 || a_dx_flush !== 1'b0)
            $display("FAIL rd_end got fd=%b dx=%b exp 0 0", a_fd_flush, a_dx_flush); else pass_cnt++;
        // redirect again while flushing restarts the hold
        ex_redirect = 1; step(); #1;
        total_cnt++; if (a_fd_flush !== 1'b1 || a_dx_flush !== 1'b1)
            $display("FAIL rd_restart got fd=%b dx=%b exp 1 1", a_fd_flush, a_dx_flush); else pass_cnt++;
        step(); ex_redirect = 0; #1;
        total_cnt++; if (a_fd_flush !== 1'b1 || a_dx_flush !== 1'b0 || a_flush_cnt !== 16'd3)
            $display("FAIL rd_restart_hold got fd=%b dx=%b cnt=%0d exp 1 0 3", a_fd_flush, a_dx_flush, a_flush_cnt); else pass_cnt++;
        step();
        // redirect during dut_b's STALL overrides the bubble
        set_hazard(); step(); idle(); ex_redirect = 1; #1;
        total_cnt++; if ({b_pc_en, b_fd_flush, b_dx_flush} !== 3'b111)
            $display("FAIL rd_in_stall got %b exp 111", {b_pc_en, b_fd_flush, b_dx_flush}); else pass_cnt++;
        step(); ex_redirect = 0; #1;
        total_cnt++; if (b_pc_en !== 1'b1 || b_fd_flush !== 1'b0 || b_stall_cnt !== 4'd1 || b_flush_cnt !== 4'd4)
            $display("FAIL rd_in_stall_after got pc=%b fd=%b s=%0d f=%0d exp 1 0 1 4", b_pc_en, b_fd_flush, b_stall_cnt, b_flush_cnt); else pass_cnt++;
        step();
    endtask

    task automatic test_forward();
        idle();
        ex_src = {3'd5, 3'd2}; ex_src_used = 2'b11;
        mem_write_en = 1; mem_write_reg = 3'd2; wb_write_en = 1; wb_write_reg = 3'd2; #1;
        total_cnt++; if (a_fwd !== 4'b0001 || b_fwd !== 4'b0001)
            $display("FAIL fwd_mem got a=%b b=%b exp 0001", a_fwd, b_fwd); else pass_cnt++;
        mem_write_en = 0; #1;
        total_cnt++; if (a_fwd !== 4'b0010)
            $display("FAIL fwd_wb got %b exp 0010", a_fwd); else pass_cnt++;
        mem_write_en = 1; wb_write_reg = 3'd5; #1;
        total_cnt++; if (a_fwd !== 4'b1001)
            $display("FAIL fwd_both got %b exp 1001", a_fwd); else pass_cnt++;
        ex_src_used = 2'b00; wb_write_en = 0; #1;
        total_cnt++; if (a_fwd !== 4'b0000)
            $display("FAIL fwd_unused got %b exp 0000", a_fwd); else pass_cnt++;
        ex_src = 6'b000_000; ex_src_used = 2'b11; mem_write_reg = 3'd0; #1;
        total_cnt++; if (a_fwd !== 4'b0101 || b_fwd !== 4'b0000)
            $display("FAIL fwd_zero got a=%b b=%b exp 0101 0000", a_fwd, b_fwd); else pass_cnt++;
        idle();
    endtask

    task automatic test_halt();
        do_reset();
        set_hazard(); ex_redirect = 1; wb_halt = 1; #1;
        total_cnt++; if ({a_pc_en, a_fd_en, a_fd_flush, a_dx_flush, a_halted} !== 5'b00010)
            $display("FAIL halt_cyc0 got %b exp 00010", {a_pc_en, a_fd_en, a_fd_flush, a_dx_flush, a_halted}); else pass_cnt++;
        step(); idle(); ex_redirect = 1; #1;
        total_cnt++; if (a_halted !== 1'b1 || b_halted !== 1'b1 || a_pc_en !== 1'b0 || a_fd_flush !== 1'b0)
            $display("FAIL halt_sticky got ha=%b hb=%b pc=%b fd=%b exp 1 1 0 0", a_halted, b_halted, a_pc_en, a_fd_flush); else pass_cnt++;
        step(); step();
        total_cnt++; if (a_halted !== 1'b1 || a_flush_cnt !== 16'd0 || a_stall_cnt !== 16'd0)
            $display("FAIL halt_cnts got h=%b f=%0d s=%0d exp 1 0 0", a_halted, a_flush_cnt, a_stall_cnt); else pass_cnt++;
        do_reset();
        total_cnt++; if (a_halted !== 1'b0 || a_pc_en !== 1'b1 || b_halted !== 1'b0)
            $display("FAIL halt_rst got ha=%b pc=%b hb=%b exp 0 1 0", a_halted, a_pc_en, b_halted); else pass_cnt++;
    endtask

    task automatic test_saturate();
        do_reset();
        set_hazard();
        for (int i = 0; i < 15; i++) step();
        total_cnt++; if (b_stall_cnt !== 4'd15 || a_stall_cnt !== 16'd15)
            $display("FAIL sat_stall_15 got b=%0d a=%0d exp 15 15", b_stall_cnt, a_stall_cnt); else pass_cnt++;
        for (int i = 0; i < 5; i++) step();
        total_cnt++; if (b_stall_cnt !== 4'd15 || a_stall_cnt !== 16'd20)
            $display("FAIL sat_stall_hold got b=%0d a=%0d exp 15 20", b_stall_cnt, a_stall_cnt); else pass_cnt++;
        idle(); ex_redirect = 1;
        for (int i = 0; i < 20; i++) step();
        total_cnt++; if (b_flush_cnt !== 4'd15 || a_flush_cnt !== 16'd20)
            $display("FAIL sat_flush got b=%0d a=%0d exp 15 20", b_flush_cnt, a_flush_cnt); else pass_cnt++;
        idle();
    endtask

    initial begin
        idle(); rst = 1;
        test_reset();
        test_load_use();
        test_redirect();
        test_forward();
        test_halt();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
